// File: rtl/fpa_add_pkg.sv
// rtl/fpa_add_pkg.sv - shared types and sizing helpers for the sequential adders
package fpa_add_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } icr_state_t;

    // Iteration-count width: must hold 0..n+1 without wrapping.
    function automatic int icr_iw(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/half_add_stage.sv
// rtl/half_add_stage.sv - bitwise half-add stage producing sum and generate vectors
module half_add_stage #(
    parameter int W = 33
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] s,
    output logic [W-1:0] g
);

    assign s = x ^ y;
    assign g = x & y;

endmodule

// File: rtl/iterative_carry_resolve_add.sv
// rtl/iterative_carry_resolve_add.sv - multi-cycle adder folding carries through one half-add stage
module iterative_carry_resolve_add
    import fpa_add_pkg::*;
#(
    parameter  int N  = 32,
    localparam int IW = icr_iw(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic          ci,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  c,
    output logic          co,
    output logic [IW-1:0] iters
);

    icr_state_t    state_q, state_d;
    logic [N:0]    s_q, s_d;
    logic [N:0]    k_q, k_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  c_q, c_d;
    logic          co_q, co_d;
    logic [IW-1:0] iters_q, iters_d;
    logic          out_valid_q, out_valid_d;

    logic [N:0]    ha_x, ha_y, ha_s, ha_g, g_shl;

    // The single half-add stage sees the operands while idle and the (s,k) pair while resolving.
    half_add_stage #(.W(N + 1)) u_half_add (
        .x (ha_x),
        .y (ha_y),
        .s (ha_s),
        .g (ha_g)
    );

    // Operand mux into the half-add stage; the generate vector becomes the next carry by a left shift.
    always_comb begin
        ha_x = s_q;
        ha_y = k_q;
        if (state_q == IDLE) begin
            ha_x = {1'b0, a};
            ha_y = {1'b0, b};
        end
        // Bit N of the generate vector is always 0 here, so dropping it on the shift loses nothing.
        g_shl = ha_g << 1;
    end

    // Next-state and datapath update: load, fold carries until none remain, then hold the result.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        c_d         = c_q;
        co_d        = co_q;
        iters_d     = iters_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d     = ha_s;
                    k_d     = g_shl | {{N{1'b0}}, ci};
                    cnt_d   = '0;
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                if (k_q != '0) begin
                    s_d   = ha_s;
                    k_d   = g_shl;
                    cnt_d = cnt_q + IW'(1);
                end else begin
                    c_d         = s_q[N-1:0];
                    co_d        = s_q[N];
                    iters_d     = cnt_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_q         <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            c_q         <= '0;
            co_q        <= 1'b0;
            iters_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            c_q         <= c_d;
            co_q        <= co_d;
            iters_q     <= iters_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign co        = co_q;
    assign iters     = iters_q;

endmodule

// File: tb/tb_iterative_carry_resolve_add.sv
// tb/tb_iterative_carry_resolve_add.sv - self-checking bench for iterative_carry_resolve_add
module tb_iterative_carry_resolve_add;

    localparam int IW8  = 4;
    localparam int IW32 = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic            in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
    logic [7:0]      a8 = '0, b8 = '0, c8;
    logic            ci8 = 1'b0, co8;
    logic [IW8-1:0]  iters8;

    logic            in_valid32 = 1'b0, in_ready32, out_valid32, out_ready32 = 1'b0;
    logic [31:0]     a32 = '0, b32 = '0, c32;
    logic            ci32 = 1'b0, co32;
    logic [IW32-1:0] iters32;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    iterative_carry_resolve_add #(.N(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .ci        (ci8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .c         (c8),
        .co        (co8),
        .iters     (iters8)
    );

    iterative_carry_resolve_add #(.N(32)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .a         (a32),
        .b         (b32),
        .ci        (ci32),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .c         (c32),
        .co        (co32),
        .iters     (iters32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact sum by plain addition; update count by repeatedly applying the
    // fold rule (s^k, (s&k)<<1) on (n+1)-bit values until the pending carry vanishes.
    function automatic int model_iters(input logic [63:0] a, input logic [63:0] b,
                                       input logic ci, input int n);
        logic [63:0] mask, s, k, t;
        int it;
        mask = (64'd1 << (n + 1)) - 64'd1;
        s = (a ^ b) & mask;
        k = (((a & b) << 1) | {63'd0, ci}) & mask;
        it = 0;
        while (k != 0 && it < 200) begin
            t = s;
            s = s ^ k;
            k = ((t & k) << 1) & mask;
            it++;
        end
        return it;
    endfunction

    // One N=8 operation; holds out_ready low for 'hold' cycles while offering ignored operands.
    task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tci,
                           input int hold, output logic [7:0] rc, output logic rco,
                           output logic [IW8-1:0] rit, output int lat);
        @(negedge clk);
        chk("in_ready8_before_accept", {63'd0, in_ready8}, 64'd1);
        a8 = ta; b8 = tb_; ci8 = tci; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid8_timeout", {63'd0, out_valid8}, 64'd1);
        rc = c8; rco = co8; rit = iters8;
        for (int h = 0; h < hold; h++) begin
            in_valid8 = 1'b1; a8 = 8'h11; b8 = 8'h22; ci8 = 1'b1;
            @(posedge clk); #1;
            chk("hold_out_valid8", {63'd0, out_valid8}, 64'd1);
            chk("hold_c8", {56'd0, c8}, {56'd0, rc});
            chk("hold_co8", {63'd0, co8}, {63'd0, rco});
            chk("hold_iters8", {60'd0, iters8}, {60'd0, rit});
            chk("hold_in_ready8", {63'd0, in_ready8}, 64'd0);
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        in_valid8 = 1'b0;
        chk("out_valid8_after_ack", {63'd0, out_valid8}, 64'd0);
        chk("in_ready8_after_ack", {63'd0, in_ready8}, 64'd1);
    endtask

    task automatic run_op32(input logic [31:0] ta, input logic [31:0] tb_, input logic tci);
        int lat;
        int m;
        logic [32:0] exp_sum;
        @(negedge clk);
        a32 = ta; b32 = tb_; ci32 = tci; in_valid32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        lat = 0;
        while (!out_valid32 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid32_timeout", {63'd0, out_valid32}, 64'd1);
        exp_sum = {1'b0, ta} + {1'b0, tb_} + {32'd0, tci};
        m = model_iters({32'd0, ta}, {32'd0, tb_}, tci, 32);
        chk("sum32", {31'd0, co32, c32}, {31'd0, exp_sum});
        chk("iters32", {58'd0, iters32}, 64'(m));
        chk("iters32_bound", {63'd0, (iters32 <= 6'd33)}, 64'd1);
        chk("lat32", 64'(lat), 64'(m + 1));
        out_ready32 = 1'b1;
        @(posedge clk); #1;
        out_ready32 = 1'b0;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] exp_c;
        logic       exp_co;
        int         exp_iters;
        int         exp_lat;
        int         hold;
    } vec_t;

    initial begin
        vec_t vecs[5];
        logic [7:0] rc;
        logic rco;
        logic [IW8-1:0] rit;
        int lat;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1, 0};
        vecs[1] = '{8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0, 0, 1, 0};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 9, 10, 0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1, 2, 0};
        vecs[4] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 3, 4, 5};

        #2;
        chk("reset_in_ready", {63'd0, in_ready8}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid8}, 64'd0);
        chk("reset_c", {56'd0, c8}, 64'd0);
        chk("reset_co", {63'd0, co8}, 64'd0);
        chk("reset_iters", {60'd0, iters8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_op8(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].hold, rc, rco, rit, lat);
            chk($sformatf("vec%0d_c", i), {56'd0, rc}, {56'd0, vecs[i].exp_c});
            chk($sformatf("vec%0d_co", i), {63'd0, rco}, {63'd0, vecs[i].exp_co});
            chk($sformatf("vec%0d_iters", i), {60'd0, rit}, 64'(vecs[i].exp_iters));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
        end

        // Reset during the fourth carry-fold of the worst-case operands.
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b1; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("mid_in_ready", {63'd0, in_ready8}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {63'd0, out_valid8}, 64'd0);
        chk("abort_c", {56'd0, c8}, 64'd0);
        chk("abort_co", {63'd0, co8}, 64'd0);
        chk("abort_iters", {60'd0, iters8}, 64'd0);
        chk("abort_in_ready", {63'd0, in_ready8}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op8(8'hFF, 8'h00, 1'b1, 0, rc, rco, rit, lat);
        chk("post_reset_sum", {55'd0, rco, rc}, 64'h100);
        chk("post_reset_iters", {60'd0, rit}, 64'd9);
        chk("post_reset_lat", 64'(lat), 64'd10);

        // Random N=8 operations with random backpressure.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            logic rci;
            int m;
            ra = 8'($urandom); rb = 8'($urandom); rci = 1'($urandom);
            run_op8(ra, rb, rci, int'($urandom_range(0, 3)), rc, rco, rit, lat);
            m = model_iters({56'd0, ra}, {56'd0, rb}, rci, 8);
            chk("rand8_sum", {55'd0, rco, rc}, 64'({1'b0, ra} + {1'b0, rb} + {8'd0, rci}));
            chk("rand8_iters", {60'd0, rit}, 64'(m));
            chk("rand8_iters_bound", {63'd0, (rit <= 4'd9)}, 64'd1);
            chk("rand8_lat", 64'(lat), 64'(m + 1));
        end

        // N=32 soak, including the long ripple corner.
        run_op32(32'hFFFF_FFFF, 32'h0, 1'b1);
        run_op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 30; i++) begin
            run_op32($urandom, $urandom, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
